// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem reads and fills the IF/ID latch.
// Optional feature: define FETCH_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ihit_i,
  input  logic [WORD_W-1:0] iload_i,
  output logic              imemREN_o,
  output logic [WORD_W-1:0] imemaddr_o,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] instr_pc_o,
  output logic [WORD_W-1:0] npc_o,
  output logic              instr_valid_o,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              halted_o
);

  typedef enum logic {FETCH, HALTED} state_t;

  localparam logic [WORD_W-1:0] WordMask = ~WORD_W'(3);
  localparam logic [WORD_W-1:0] PcReset  = PC_INIT & WordMask;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] instrPc_q, instrPc_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= PcReset;
      instr_q   <= '0;
      instrPc_q <= '0;
      npc_q     <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instrPc_q <= instrPc_d;
      npc_q     <= npc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == FETCH && halt_i) state_d = HALTED;
  end

  // Priority within FETCH: halt, redirect, stall, ihit, memory wait.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instrPc_d = instrPc_q;
    npc_d     = npc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    if (state_q == FETCH) begin
      if (halt_i) begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end else if (redirect_i) begin
        pc_d    = redirect_pc_i & WordMask;
        valid_d = 1'b0;
      end else if (stall_i) begin
        valid_d = valid_q;
      end else if (ihit_i) begin
        instr_d   = iload_i;
        instrPc_d = pc_q;
        npc_d     = pc_q + WORD_W'(4);
        pc_d      = pc_q + WORD_W'(4);
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    imemREN_o     = (state_q == FETCH) && !rst_i;
    imemaddr_o    = pc_q;
    instr_o       = instr_q;
    instr_pc_o    = instrPc_q;
    npc_o         = npc_q;
    instr_valid_o = valid_q;
    halted_o      = halted_q;
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stallCnt_q;
  logic        stallEvent;

  // A stalled or memory-waiting FETCH cycle counts; redirect/halt cycles do not count as waits.
  assign stallEvent = (state_q == FETCH) &&
                      (stall_i || (!ihit_i && !redirect_i && !halt_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
    end else if (stallEvent && stallCnt_q != 32'hFFFF_FFFF) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expected values are hand-computed.
// Define FETCH_STALL_CNT_EN at build time to also exercise stall_cnt_o.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, ihit, stall, redirect, halt;
  logic [31:0] iload, redirectPc;
  logic        imemREN, instrValid, halted;
  logic [31:0] imemaddr, instr, instrPc, npc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stallCnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_INIT(32'h0), .WORD_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .ihit_i(ihit), .iload_i(iload),
    .imemREN_o(imemREN), .imemaddr_o(imemaddr),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .halt_i(halt), .instr_o(instr), .instr_pc_o(instrPc), .npc_o(npc),
    .instr_valid_o(instrValid),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt_o(stallCnt),
`endif
    .halted_o(halted)
  );

  // Set inputs, then advance one clock and settle 1ns past the edge.
  task automatic applyStimulus(input logic r, input logic h, input logic [31:0] ld,
                               input logic s, input logic rd, input logic [31:0] rpc,
                               input logic hl);
    rst = r; ihit = h; iload = ld; stall = s; redirect = rd; redirectPc = rpc; halt = hl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0;
    redirect = 1'b0; redirectPc = '0; halt = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h1234_5678, 0, 0, 0, 0);
    checkOutput("rst_imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("rst_imemaddr", imemaddr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instrPc, 32'h0);
    checkOutput("rst_npc", npc, 32'h0);
    checkOutput("rst_valid", {31'b0, instrValid}, 32'h0);
    checkOutput("rst_halted", {31'b0, halted}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stallCnt, 32'h0);
`endif

    // Zero-wait fetch stream
    rst = 1'b0;
    #1;
    checkOutput("t1_imemREN", {31'b0, imemREN}, 32'h1);
    checkOutput("t1_addr0", imemaddr, 32'h0);
    applyStimulus(0, 1, 32'h2001_0005, 0, 0, 0, 0);
    checkOutput("t1_instr0", instr, 32'h2001_0005);
    checkOutput("t1_pc0", instrPc, 32'h0);
    checkOutput("t1_npc0", npc, 32'h4);
    checkOutput("t1_valid0", {31'b0, instrValid}, 32'h1);
    checkOutput("t1_addr4", imemaddr, 32'h4);
    applyStimulus(0, 1, 32'h2002_0003, 0, 0, 0, 0);
    checkOutput("t1_instr1", instr, 32'h2002_0003);
    checkOutput("t1_pc1", instrPc, 32'h4);
    checkOutput("t1_npc1", npc, 32'h8);
    checkOutput("t1_addr8", imemaddr, 32'h8);

    // Memory wait at PC=0x10
    applyStimulus(0, 1, 32'h0000_0011, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0012, 0, 0, 0, 0);
    checkOutput("t2_addr10", imemaddr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'hBAD0_0000, 0, 0, 0, 0);
      checkOutput("t2_wait_valid", {31'b0, instrValid}, 32'h0);
      checkOutput("t2_wait_addr", imemaddr, 32'h10);
      checkOutput("t2_wait_instr", instr, 32'h0000_0012);
    end
    applyStimulus(0, 1, 32'hAAAA_0010, 0, 0, 0, 0);
    checkOutput("t2_instr", instr, 32'hAAAA_0010);
    checkOutput("t2_pc", instrPc, 32'h10);
    checkOutput("t2_valid", {31'b0, instrValid}, 32'h1);
    checkOutput("t2_addr14", imemaddr, 32'h14);

    // Stall holds PC and latch
    applyStimulus(0, 1, 32'h8C22_0000, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
      checkOutput("t3_instr", instr, 32'h8C22_0000);
      checkOutput("t3_pc", instrPc, 32'h14);
      checkOutput("t3_valid", {31'b0, instrValid}, 32'h1);
      checkOutput("t3_addr", imemaddr, 32'h18);
      checkOutput("t3_imemREN", {31'b0, imemREN}, 32'h1);
    end
    applyStimulus(0, 1, 32'h1111_0018, 0, 0, 0, 0);
    checkOutput("t3_resume_instr", instr, 32'h1111_0018);
    checkOutput("t3_resume_pc", instrPc, 32'h18);
    checkOutput("t3_resume_addr", imemaddr, 32'h1C);

    // Redirect beats stall and ihit
    applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0043, 0);
    checkOutput("t4_addr", imemaddr, 32'h40);
    checkOutput("t4_valid", {31'b0, instrValid}, 32'h0);
    checkOutput("t4_instr_hold", instr, 32'h1111_0018);
    applyStimulus(0, 1, 32'h2222_0040, 0, 0, 0, 0);
    checkOutput("t4_instr", instr, 32'h2222_0040);
    checkOutput("t4_pc", instrPc, 32'h40);
    checkOutput("t4_npc", npc, 32'h44);
    checkOutput("t4_valid2", {31'b0, instrValid}, 32'h1);

    // Halt beats redirect; exit only through reset
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0100, 1);
    checkOutput("t5_halted", {31'b0, halted}, 32'h1);
    checkOutput("t5_imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("t5_addr", imemaddr, 32'h44);
    checkOutput("t5_valid", {31'b0, instrValid}, 32'h0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0200, 0);
    checkOutput("t5_sticky", {31'b0, halted}, 32'h1);
    checkOutput("t5_addr_hold", imemaddr, 32'h44);
    checkOutput("t5_instr_hold", instr, 32'h2222_0040);
    checkOutput("t5_pc_hold", instrPc, 32'h40);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_rst_halted", {31'b0, halted}, 32'h0);
    checkOutput("t5_rst_addr", imemaddr, 32'h0);
    checkOutput("t5_rst_imemREN", {31'b0, imemREN}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("t5_rel_imemREN", {31'b0, imemREN}, 32'h1);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("t5_rst_stall_cnt", stallCnt, 32'h0);
`endif

    // PC wraps at the top of the address space
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("t6_addr_top", imemaddr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 32'h3333_0000, 0, 0, 0, 0);
    checkOutput("t6_npc", npc, 32'h0);
    checkOutput("t6_pc", instrPc, 32'hFFFF_FFFC);
    checkOutput("t6_addr_wrap", imemaddr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("t6_cnt_before", stallCnt, 32'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    checkOutput("t6_stall_cnt", stallCnt, 32'h5);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
